// File: rtl/sae_arbiter.sv
// Round-robin arbiter sharing one sae core between two single-byte requesters.
// Holds core inputs for the whole operation and guards a hung core with a timeout.
module sae_arbiter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  input  logic [1:0][1:0] req_mode,
  input  logic [1:0][7:0] req_data,
  input  logic [1:0][7:0] req_key,
  output logic [1:0]      req_ready,
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic [7:0]      rsp_data,
  output logic [3:0]      rsp_err,
  output logic [1:0]      core_mode,
  output logic [7:0]      core_data,
  output logic [7:0]      core_key,
  output logic            core_inputs_valid,
  input  logic [7:0]      core_data_out,
  input  logic            core_output_ready,
  input  logic [2:0]      core_err,
  output logic            busy
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic             served;
  logic             grant;
  logic             accept;
  logic             done;
  logic             tmo;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_mode;
  logic [7:0]       op_data;
  logic [7:0]       op_key;

  // Under contention the client that was not served last wins.
  assign grant = (req_valid == 2'b11) ? ~last_grant : req_valid[1];

  always_comb begin
    state_nxt         = state;
    accept            = 1'b0;
    done              = 1'b0;
    tmo               = 1'b0;
    req_ready         = 2'b00;
    rsp_valid         = 2'b00;
    core_mode         = 2'b00;
    core_data         = 8'h00;
    core_key          = 8'h00;
    core_inputs_valid = 1'b0;
    busy              = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        // req_ready is masked by reset so it reads 0 while reset is held.
        if (!rst_n && (req_valid != 2'b00)) begin
          accept    = 1'b1;
          req_ready = {grant, ~grant};
          state_nxt = (req_mode[grant] == 2'b00) ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        core_mode         = op_mode;
        core_data         = op_data;
        core_key          = op_key;
        core_inputs_valid = 1'b1;
        state_nxt         = S_WAIT;
      end
      S_WAIT: begin
        core_mode = op_mode;
        core_data = op_data;
        core_key  = op_key;
        if (core_output_ready || (core_err != 3'b000)) begin
          done      = 1'b1;
          state_nxt = S_RESP;
        end else if (cnt == TMO_LAST) begin
          tmo       = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = {served, ~served};
        if (rsp_ready[served]) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      served     <= 1'b0;
      cnt        <= '0;
      rsp_data   <= 8'h00;
      rsp_err    <= 4'h0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant <= grant;
        served     <= grant;
        if (req_mode[grant] == 2'b00) begin
          rsp_data <= 8'h00;
          rsp_err  <= 4'h0;
        end
      end
      if (state == S_ISSUE) begin
        cnt <= '0;
      end else if (state == S_WAIT) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (done) begin
        rsp_data <= core_data_out;
        rsp_err  <= {1'b0, core_err};
      end else if (tmo) begin
        rsp_data <= 8'h00;
        rsp_err  <= 4'b1000;
      end
    end
  end

  // Operation registers: loaded only at accept, so later request changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_mode <= req_mode[grant];
      op_data <= req_data[grant];
      op_key  <= req_key[grant];
    end
  end

endmodule

// File: tb/tb_sae_arbiter.sv
// Directed and randomized checks of sae_arbiter against a core stub and
// a request-level reference model (result = data^key, error/timeout rules, round-robin).
module tb_sae_arbiter;

  logic            clk;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [1:0][1:0] req_mode;
  logic [1:0][7:0] req_data;
  logic [1:0][7:0] req_key;
  logic [1:0]      req_ready;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [7:0]      rsp_data;
  logic [3:0]      rsp_err;
  logic [1:0]      core_mode;
  logic [7:0]      core_data;
  logic [7:0]      core_key;
  logic            core_inputs_valid;
  logic [7:0]      core_data_out;
  logic            core_output_ready;
  logic [2:0]      core_err;
  logic            busy;

  int         tests;
  int         fails;
  int         pulses;
  int         gap_viol;
  bit         idle_seen;
  logic [2:0] err_knob;
  bit         hang;
  logic [1:0] sr;

  sae_arbiter #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_mode(req_mode), .req_data(req_data), .req_key(req_key),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .core_mode(core_mode), .core_data(core_data), .core_key(core_key),
    .core_inputs_valid(core_inputs_valid), .core_data_out(core_data_out),
    .core_output_ready(core_output_ready), .core_err(core_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core stub: answers two cycles after the inputs_valid pulse.
  always @(posedge clk or posedge rst_n) begin
    if (rst_n) sr <= 2'b00;
    else       sr <= {sr[0], core_inputs_valid};
  end
  assign core_output_ready = sr[1] && !hang && (err_knob == 3'b000);
  assign core_err          = (sr[1] && !hang) ? err_knob : 3'b000;
  assign core_data_out     = core_data ^ core_key;

  // Pulse counter and idle-gap monitor between core operations.
  always @(posedge clk) begin
    if (!rst_n) begin
      if (core_inputs_valid) begin
        pulses <= pulses + 1;
        if (!idle_seen) gap_viol <= gap_viol + 1;
        idle_seen <= 1'b0;
      end else if (core_mode == 2'b00) begin
        idle_seen <= 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Expected {rsp_err, rsp_data} of one operation under the current stub knobs.
  function automatic logic [11:0] model(input logic [1:0] m, input logic [7:0] d, input logic [7:0] k);
    if (m == 2'b00)             return 12'h000;
    if (hang)                   return {4'b1000, 8'h00};
    if (err_knob != 3'b000)     return {1'b0, err_knob, d ^ k};
    return {4'b0000, d ^ k};
  endfunction

  task automatic run_op(input int c, input logic [1:0] m, input logic [7:0] d, input logic [7:0] k,
                        output int acc_wait, output int lat);
    int n;
    logic [11:0] exp;
    exp = model(m, d, k);
    req_valid[c] = 1'b1; req_mode[c] = m; req_data[c] = d; req_key[c] = k;
    #1;
    n = 0;
    while (req_ready[c] !== 1'b1 && n < 50) begin step(); n++; end
    acc_wait = n;
    check("req_ready", req_ready[c], 1);
    step();
    req_valid[c] = 1'b0; req_mode[c] = ~m; req_data[c] = ~d; req_key[c] = 8'($urandom);
    #1;
    if (m != 2'b00) begin
      check("issue_ivalid", core_inputs_valid, 1);
      check("issue_mode", core_mode, m);
      check("issue_data", core_data, d);
      check("issue_key", core_key, k);
    end else begin
      check("noop_ivalid", core_inputs_valid, 0);
    end
    n = 0;
    while (rsp_valid[c] !== 1'b1 && n < 100) begin step(); n++; end
    lat = n;
    check("rsp_valid", rsp_valid, 2'b01 << c);
    check("rsp_data", rsp_data, exp[7:0]);
    check("rsp_err", rsp_err, exp[11:8]);
    rsp_ready[c] = 1'b1;
    step();
    rsp_ready[c] = 1'b0;
    #1;
    check("busy_after_rsp", busy, 0);
  endtask

  initial begin
    int aw, lat, n, g, model_last, p0, hold;
    logic [1:0]  m;
    logic [7:0]  d, k, snap;
    logic [11:0] exp;
    tests = 0; fails = 0; pulses = 0; gap_viol = 0; idle_seen = 1'b1;
    err_knob = 3'b000; hang = 1'b0;
    rst_n = 1'b1;
    req_valid = 2'b11; req_mode = '0; req_data = '0; req_key = '0; rsp_ready = 2'b11;

    // Reset state, with requests pending to show req_ready stays low.
    repeat (2) step();
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_core_mode", core_mode, 0);
    check("rst_ivalid", core_inputs_valid, 0);
    check("rst_busy", busy, 0);
    req_valid = 2'b00; rsp_ready = 2'b00;
    rst_n = 1'b0;
    step();

    // Single encrypt request from client 0.
    run_op(0, 2'b10, 8'h41, 8'h05, aw, lat);
    check("single_acc_wait", aw, 0);
    check("single_latency", lat, 3);

    // Contention after reset: both clients request continuously.
    rst_n = 1'b1; step(); rst_n = 1'b0; step();
    model_last = 1;
    p0 = pulses;
    req_valid = 2'b11;
    for (int c = 0; c < 2; c++) begin
      req_mode[c] = 2'b01; req_data[c] = 8'($urandom); req_key[c] = 8'($urandom);
    end
    #1;
    for (int i = 0; i < 24; i++) begin
      n = 0;
      while (req_ready === 2'b00 && n < 50) begin step(); n++; end
      g = 1 - model_last;
      check("rr_grant", req_ready, 2'b01 << g);
      model_last = g;
      m = req_mode[g]; d = req_data[g]; k = req_key[g];
      exp = model(m, d, k);
      step();
      req_mode[g] = (i < 3) ? 2'b01 : 2'($urandom);
      req_data[g] = 8'($urandom); req_key[g] = 8'($urandom);
      n = 0;
      while (rsp_valid[g] !== 1'b1 && n < 100) begin step(); n++; end
      check("rr_rsp_data", rsp_data, exp[7:0]);
      check("rr_rsp_err", rsp_err, exp[11:8]);
      hold = $urandom_range(0, 3);
      snap = rsp_data;
      for (int h = 0; h < hold; h++) begin
        step();
        check("rr_hold_valid", rsp_valid, 2'b01 << g);
        check("rr_hold_data", rsp_data, snap);
        check("rr_hold_no_grant", req_ready, 0);
      end
      rsp_ready[g] = 1'b1; step(); rsp_ready[g] = 1'b0; #1;
      if (i == 3) check("rr_pulses_4", pulses - p0, 4);
    end
    req_valid = 2'b00;
    step();

    // Core error on client 1, then a normal request from client 1.
    err_knob = 3'b010;
    run_op(1, 2'b01, 8'h00, 8'h5a, aw, lat);
    err_knob = 3'b000;
    run_op(1, 2'b10, 8'h33, 8'h0f, aw, lat);
    check("after_err_latency", lat, 3);

    // Timeout: 1 ISSUE cycle + 16 WAIT cycles before the response.
    hang = 1'b1;
    run_op(0, 2'b11, 8'h12, 8'h34, aw, lat);
    check("timeout_latency", lat, 17);
    hang = 1'b0;

    // Backpressure on client 0 while client 1 waits.
    req_valid[0] = 1'b1; req_mode[0] = 2'b10; req_data[0] = 8'h5c; req_key[0] = 8'h21;
    #1;
    check("bp_accept0", req_ready, 2'b01);
    step();
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b1; req_mode[1] = 2'b01; req_data[1] = 8'h00; req_key[1] = 8'h77;
    n = 0;
    while (rsp_valid[0] !== 1'b1 && n < 100) begin step(); n++; end
    for (int h = 0; h < 5; h++) begin
      check("bp_valid", rsp_valid, 2'b01);
      check("bp_data", rsp_data, 8'h7d);
      check("bp_no_grant", req_ready, 2'b00);
      step();
    end
    rsp_ready[0] = 1'b1; step(); rsp_ready[0] = 1'b0; #1;
    check("bp_grant1_next", req_ready, 2'b10);
    step();
    req_valid[1] = 1'b0;
    n = 0;
    while (rsp_valid[1] !== 1'b1 && n < 100) begin step(); n++; end
    check("bp_rsp1_data", rsp_data, 8'h77);
    rsp_ready[1] = 1'b1; step(); rsp_ready[1] = 1'b0;

    // No-op request never touches the core.
    p0 = pulses;
    run_op(1, 2'b00, 8'hff, 8'hee, aw, lat);
    check("noop_latency", lat, 0);
    check("noop_no_pulse", pulses - p0, 0);

    // Reset asserted in the middle of WAIT.
    hang = 1'b1;
    req_valid[0] = 1'b1; req_mode[0] = 2'b10; req_data[0] = 8'h10; req_key[0] = 8'h01;
    step();
    req_valid[0] = 1'b0;
    step(); step();
    check("midrst_pre_mode", core_mode, 2'b10);
    rst_n = 1'b1;
    #1;
    check("midrst_mode", core_mode, 0);
    check("midrst_data", core_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_req_ready", req_ready, 0);
    hang = 1'b0;
    step();
    rst_n = 1'b0;
    for (int h = 0; h < 3; h++) begin
      check("midrst_no_stale", rsp_valid, 0);
      step();
    end
    run_op(0, 2'b10, 8'h61, 8'h20, aw, lat);
    check("midrst_new_latency", lat, 3);

    check("idle_gap", gap_viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
